hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the enable/flush inputs of all four inter-stage latches (if_dc, dc_ex, ex_mem, mem_wb) and the PC enable.
- Within the dc_ex interface it is the producing end: it generates id_en2 and hz_flushed2, which the latch consumes.
- Resolves, in priority order: data-memory wait, EX-stage redirect (branch/jump), load-use, instruction-fetch miss.
- Tracks halt so the pipeline freezes cleanly, and keeps saturating performance counters.

Parameters:
- REGW, 5, register-select width.
- CNTW, 16, width of each performance counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_d_ren  in  1  load in MEM stage (ex_mem output).
- mem_d_wen  in  1  store in MEM stage.
- mem_halt  in  1  halt instruction in MEM stage.
- ex_d_ren  in  1  load in EX stage (dc_ex d_ren output).
- ex_wsel  in  REGW  destination of EX instruction.
- ex_redirect  in  1  branch taken or jump resolved in EX.
- dc_rsel1  in  REGW  rs of DC instruction.
- dc_rsel2  in  REGW  rt of DC instruction.
- dc_uses_rs2  in  1  DC instruction reads rt.
- pc_en  out  1  PC register load enable.
- fd_en, fd_flush  out  1 each  if_dc latch controls.
- id_en2, hz_flushed2  out  1 each  dc_ex latch controls.
- em_en, em_flush  out  1 each  ex_mem latch controls.
- mw_en, mw_flush  out  1 each  mem_wb latch controls.
- halted  out  1  pipeline stopped on halt.
- stall_cnt  out  CNTW  cycles with pc_en=0 while not halted.
- redirect_cnt  out  CNTW  number of EX redirects.

Behaviour:
- Clocking and reset
  - One clock, CLK. Reset RST is synchronous and active-high.
  - Latch outputs are Mealy functions of state and inputs, settled within the same cycle they are sampled.
- Reset
  - On a CLK edge with RST=1: state←RUN, both counters←0.
  - While RST=1, outputs are forced regardless of state: all enables and pc_en =0; all flushes =1; halted=0.
  - RST asserted mid-stall or in HALTED wins unconditionally.
- FSM: RUN, MEM_WAIT, HALTED.
  - Let memreq = mem_d_ren | mem_d_wen.
  - RUN→MEM_WAIT when memreq & !dhit.
  - MEM_WAIT→RUN on the cycle dhit=1. That cycle uses RUN output rules.
  - RUN→HALTED when mem_halt & !(memreq & !dhit).
  - MEM_WAIT→HALTED when dhit=1 and mem_halt=1.
  - HALTED is sticky until RST.
- Priority 1, data wait (memreq & !dhit, in RUN or MEM_WAIT):
  - pc_en=fd_en=id_en2=em_en=0; mw_flush=1 (bubble into WB).
  - All other flushes =0.
  - ex_redirect is ignored this cycle; the EX instruction is held and re-evaluated.
- Priority 2, redirect (ex_redirect=1):
  - pc_en=1 regardless of ihit.
  - fd_flush=1, hz_flushed2=1; em_en=1, mw_en=1.
  - Load-use and ihit are ignored.
  - redirect_cnt += 1, saturating at all-ones.
- Priority 3, load-use:
  - Condition: ex_d_ren & ex_wsel≠0 & (ex_wsel==dc_rsel1 | (dc_uses_rs2 & ex_wsel==dc_rsel2)).
  - Outputs: pc_en=0, fd_en=0, hz_flushed2=1, em_en=1, mw_en=1.
  - Exactly one bubble per load: the next cycle the load is in MEM, so the condition self-clears.
- Priority 4, fetch miss (ihit=0):
  - pc_en=0, fd_flush=1; id_en2=em_en=mw_en=1.
- Otherwise: all enables =1, all flushes =0.
- HALTED:
  - pc_en=fd_en=id_en2=em_en=0, mw_flush=1, halted=1; other flushes =0.
  - Counters frozen.
- Flush and enable are never both 1 on the same latch.
- stall_cnt increments (saturating) each non-reset cycle in RUN or MEM_WAIT with pc_en=0.
- Register $0 never causes a load-use stall.

Test Plan:
- Reset: RST=1 for 2 cycles, then 0 with ihit=1 and no hazards → first cycle after release: all en=1, all flush=0, stall_cnt=0, redirect_cnt=0.
- Load-use: ex_d_ren=1, ex_wsel=5, dc_rsel1=5 → one cycle with pc_en=0, fd_en=0, hz_flushed2=1; next cycle (ex_d_ren=0) normal; stall_cnt=1.
- Load-use on $0: ex_wsel=0, dc_rsel1=0 → no stall. Also dc_uses_rs2=0 with rt match → no stall.
- Data wait: memreq=1, dhit=0 for 3 cycles, then 1 → state MEM_WAIT for 3 cycles with id_en2=0 and mw_flush=1; release on the dhit cycle; stall_cnt=3.
- Simultaneous events:
  - ex_redirect=1 with load-use and ihit=0 → pc_en=1, fd_flush=1, hz_flushed2=1, redirect_cnt+1.
  - Same case plus memreq&!dhit → data-wait outputs only; redirect_cnt unchanged.
- Halt: mem_halt=1 with dhit=1 → next cycle halted=1, pc_en=0; stays halted for 10 cycles despite ex_redirect pulses; RST=1 returns to RUN with counters at 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath (master) reports stage status; the controller (slave) returns latch controls.
interface hazard_ctrl_if #(
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic            ihit;
    logic            dhit;
    logic            mem_d_ren;
    logic            mem_d_wen;
    logic            mem_halt;
    logic            ex_d_ren;
    logic [REGW-1:0] ex_wsel;
    logic            ex_redirect;
    logic [REGW-1:0] dc_rsel1;
    logic [REGW-1:0] dc_rsel2;
    logic            dc_uses_rs2;

    logic            pc_en;
    logic            fd_en;
    logic            fd_flush;
    logic            id_en2;
    logic            hz_flushed2;
    logic            em_en;
    logic            em_flush;
    logic            mw_en;
    logic            mw_flush;
    logic            halted;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] redirect_cnt;

    modport master (
        output ihit, dhit, mem_d_ren, mem_d_wen, mem_halt, ex_d_ren, ex_wsel,
               ex_redirect, dc_rsel1, dc_rsel2, dc_uses_rs2,
        input  pc_en, fd_en, fd_flush, id_en2, hz_flushed2, em_en, em_flush,
               mw_en, mw_flush, halted, stall_cnt, redirect_cnt
    );

    modport slave (
        input  ihit, dhit, mem_d_ren, mem_d_wen, mem_halt, ex_d_ren, ex_wsel,
               ex_redirect, dc_rsel1, dc_rsel2, dc_uses_rs2,
        output pc_en, fd_en, fd_flush, id_en2, hz_flushed2, em_en, em_flush,
               mw_en, mw_flush, halted, stall_cnt, redirect_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data wait > EX redirect > load-use > fetch miss,
// plus halt freeze and saturating stall/redirect counters.
module hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  hif
);
    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALTED} state_t;

    state_t          r_state, w_next;
    logic [CNTW-1:0] r_stall_cnt, r_redirect_cnt;

    logic w_memreq, w_dwait, w_loaduse, w_active, w_redirect_taken;
    logic w_pc_en, w_fd_en, w_fd_flush, w_id_en2, w_hz_flushed2;
    logic w_em_en, w_em_flush, w_mw_en, w_mw_flush, w_halted;

    assign w_memreq  = hif.mem_d_ren | hif.mem_d_wen;
    assign w_dwait   = w_memreq & ~hif.dhit;
    assign w_active  = (r_state != S_HALTED);
    // $0 is hardwired, so a load targeting it can never create a dependency
    assign w_loaduse = hif.ex_d_ren & (hif.ex_wsel != '0) &
                       ((hif.ex_wsel == hif.dc_rsel1) |
                        (hif.dc_uses_rs2 & (hif.ex_wsel == hif.dc_rsel2)));
    assign w_redirect_taken = w_active & ~w_dwait & hif.ex_redirect;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_RUN;
        else     r_state <= w_next;
    end

    // RUN and MEM_WAIT share transitions: stay waiting while the access is
    // outstanding, otherwise halt if a halt has reached MEM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN, S_MEM_WAIT: begin
                if (w_dwait)           w_next = S_MEM_WAIT;
                else if (hif.mem_halt) w_next = S_HALTED;
                else                   w_next = S_RUN;
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_RUN;
        endcase
    end

    always_comb begin
        w_pc_en       = 1'b1;
        w_fd_en       = 1'b1;
        w_fd_flush    = 1'b0;
        w_id_en2      = 1'b1;
        w_hz_flushed2 = 1'b0;
        w_em_en       = 1'b1;
        w_em_flush    = 1'b0;
        w_mw_en       = 1'b1;
        w_mw_flush    = 1'b0;
        w_halted      = 1'b0;
        if (RST) begin
            w_pc_en       = 1'b0;
            w_fd_en       = 1'b0;
            w_fd_flush    = 1'b1;
            w_id_en2      = 1'b0;
            w_hz_flushed2 = 1'b1;
            w_em_en       = 1'b0;
            w_em_flush    = 1'b1;
            w_mw_en       = 1'b0;
            w_mw_flush    = 1'b1;
        end else if (!w_active || w_dwait) begin
            // Freeze everything upstream of WB and bubble the WB stage
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_id_en2   = 1'b0;
            w_em_en    = 1'b0;
            w_mw_en    = 1'b0;
            w_mw_flush = 1'b1;
            w_halted   = !w_active;
        end else if (hif.ex_redirect) begin
            w_fd_en       = 1'b0;
            w_fd_flush    = 1'b1;
            w_id_en2      = 1'b0;
            w_hz_flushed2 = 1'b1;
        end else if (w_loaduse) begin
            w_pc_en       = 1'b0;
            w_fd_en       = 1'b0;
            w_id_en2      = 1'b0;
            w_hz_flushed2 = 1'b1;
        end else if (!hif.ihit) begin
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_fd_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else if (w_active) begin
            if (!w_pc_en && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect_taken && r_redirect_cnt != '1)
                r_redirect_cnt <= r_redirect_cnt + 1'b1;
        end
    end

    assign hif.pc_en        = w_pc_en;
    assign hif.fd_en        = w_fd_en;
    assign hif.fd_flush     = w_fd_flush;
    assign hif.id_en2       = w_id_en2;
    assign hif.hz_flushed2  = w_hz_flushed2;
    assign hif.em_en        = w_em_en;
    assign hif.em_flush     = w_em_flush;
    assign hif.mw_en        = w_mw_en;
    assign hif.mw_flush     = w_mw_flush;
    assign hif.halted       = w_halted;
    assign hif.stall_cnt    = r_stall_cnt;
    assign hif.redirect_cnt = r_redirect_cnt;
endmodule
